// File: rtl/conv_ctrl_mc.sv
// Convolution sequencer: walks FETCH/LDW/LDY/LDX/PRE/COMP/RWND once per
// output channel, with hold stalls, abort/stopper flush and done pulse.
module conv_ctrl_mc #(
  parameter int ADDR_W     = 12,
  parameter int CH_W       = 2,
  parameter int NUM_CH     = 4,
  parameter int WSTRIDE    = 16,
  parameter int PRE_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dut_run,
  input  logic              stopper,
  input  logic              abort,
  input  logic              hold,
  input  logic              x_dim_zero_flag,
  input  logic              x_dim_sec_flag,
  output logic              inc,
  output logic              dec,
  output logic              PCout,
  output logic              data_or_dim,
  output logic              x_or_y,
  output logic              weight_data_sel,
  output logic              y_sel,
  output logic [1:0]        sel,
  output logic              we,
  output logic              Out_PC_inc,
  output logic              Out_PC_out,
  output logic [ADDR_W-1:0] weight_PC,
  output logic [CH_W-1:0]   ch_idx,
  output logic              dut_busy,
  output logic              flush,
  output logic              done
);

  localparam int PW = $clog2(PRE_CYCLES + 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRE_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LDW,
    S_LDY,
    S_LDX,
    S_PRE,
    S_COMP,
    S_RWND,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            busy_q;
  logic [31:0]     wpc_full;

  // State, channel, prefetch count and busy flag registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pre_q   <= pre_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state: abort beats hold, hold freezes everything else
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pre_d   = pre_q;
    if (state_q == S_IDLE) begin
      if (dut_run) begin
        state_d = S_FETCH;
        ch_d    = '0;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else if (!hold) begin
      case (state_q)
        S_FETCH: state_d = stopper ? S_IDLE : S_LDW;
        S_LDW:   state_d = S_LDY;
        S_LDY:   state_d = S_LDX;
        S_LDX: begin
          state_d = S_PRE;
          pre_d   = '0;
        end
        S_PRE: begin
          if (pre_q == PRE_LAST) state_d = S_COMP;
          else pre_d = pre_q + 1'b1;
        end
        S_COMP: if (x_dim_zero_flag) state_d = S_RWND;
        S_RWND: begin
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            ch_d    = ch_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wpc_full = 32'(ch_q) * 32'(WSTRIDE) + 32'd1;

  // Output decode from state, then flush and hold masking
  always_comb begin
    inc             = 1'b0;
    dec             = 1'b0;
    PCout           = 1'b0;
    data_or_dim     = 1'b0;
    x_or_y          = 1'b0;
    weight_data_sel = 1'b0;
    y_sel           = 1'b0;
    sel             = 2'd0;
    we              = 1'b0;
    Out_PC_inc      = 1'b0;
    Out_PC_out      = 1'b0;
    flush           = 1'b0;
    done            = 1'b0;
    weight_PC       = '0;
    case (state_q)
      S_FETCH: begin
        inc   = 1'b1;
        PCout = 1'b1;
        flush = stopper & ~hold;
      end
      S_LDW: begin
        inc             = 1'b1;
        PCout           = 1'b1;
        weight_data_sel = 1'b1;
      end
      S_LDY: begin
        inc             = 1'b1;
        PCout           = 1'b1;
        x_or_y          = 1'b1;
        weight_data_sel = 1'b1;
        y_sel           = 1'b1;
        sel             = 2'd2;
      end
      S_LDX, S_PRE: begin
        inc         = 1'b1;
        PCout       = 1'b1;
        data_or_dim = 1'b1;
        x_or_y      = 1'b1;
        sel         = 2'd1;
      end
      S_COMP: begin
        PCout       = 1'b1;
        data_or_dim = 1'b1;
        x_or_y      = 1'b1;
        we          = 1'b1;
        Out_PC_inc  = 1'b1;
        Out_PC_out  = 1'b1;
        sel         = 2'd1;
        inc         = ~x_dim_sec_flag;
        dec         = x_dim_sec_flag;
      end
      S_RWND: begin
        PCout       = 1'b1;
        dec         = 1'b1;
        data_or_dim = 1'b1;
        x_or_y      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    if (state_q != S_IDLE) begin
      weight_PC = wpc_full[ADDR_W-1:0];
      if (abort) flush = 1'b1;
      if (hold) begin
        inc        = 1'b0;
        dec        = 1'b0;
        we         = 1'b0;
        Out_PC_inc = 1'b0;
      end
    end
  end

  assign ch_idx   = ch_q;
  assign dut_busy = busy_q;

endmodule
